// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared state, opcode and datapath-select encodings for the multi-cycle core controller
package core_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WRITE, MEM_WB, EXEC_R, EXEC_I, ALU_WB, BRANCH, HALT
  } state_t;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  function automatic logic is_mem_op(input logic [6:0] op);
    return op == OPC_LOAD || op == OPC_STORE;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts unanswered memory request cycles (clk, reset, req, ready in; timeout out)
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ready,
  output logic timeout
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset || !req || ready) ? '0 : cnt + 1'b1;
  assign timeout = req && !ready && cnt == CNT_W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM (clk, reset, opcode, alu_zero, mem_ready in; datapath selects/enables, fault flags, state out)
module multicycle_controller
  import core_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_source,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       mem_fault,
  output logic [3:0] state
);
  state_t cur, nxt;
  logic timeout;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .req(mem_req), .ready(mem_ready), .timeout(timeout)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= FETCH;
      illegal_instr <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      cur <= nxt;
      illegal_instr <= illegal_instr | (cur == DECODE && nxt == HALT);
      mem_fault <= mem_fault | timeout;
    end
  end
  always_comb begin
    nxt = cur;
    mem_req = 1'b0;
    mem_we = 1'b0;
    iord = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_source = 1'b0;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_REG;
    alu_op = ALU_ADD;
    reg_write = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    case (cur)
      FETCH: begin
        mem_req = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write = mem_ready;
        pc_write = mem_ready;
        nxt = mem_ready ? DECODE : timeout ? HALT : FETCH;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMMSH;
        nxt = is_mem_op(opcode) ? MEM_ADDR :
              opcode == OPC_OP ? EXEC_R :
              opcode == OPC_OPIMM ? EXEC_I :
              opcode == OPC_BRANCH ? BRANCH : HALT;
      end
      MEM_ADDR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        nxt = opcode == OPC_LOAD ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_req = 1'b1;
        iord = 1'b1;
        nxt = mem_ready ? MEM_WB : timeout ? HALT : MEM_READ;
      end
      MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        iord = 1'b1;
        instr_done = mem_ready;
        nxt = mem_ready ? FETCH : timeout ? HALT : MEM_WRITE;
      end
      MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        nxt = FETCH;
      end
      EXEC_R: begin
        alu_src_a = SRCA_REG;
        alu_op = ALU_FUNCT;
        nxt = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_op = ALU_FUNCT;
        nxt = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        instr_done = 1'b1;
        nxt = FETCH;
      end
      BRANCH: begin
        alu_src_a = SRCA_REG;
        alu_op = ALU_SUB;
        pc_source = 1'b1;
        pc_write = alu_zero;
        instr_done = 1'b1;
        nxt = FETCH;
      end
      default: nxt = HALT;
    endcase
  end
  assign state = cur;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-cycle vector table checked through an expectation queue
module tb_multicycle_controller;
  import core_ctrl_pkg::*;
  logic clk = 1'b0, reset = 1'b1, alu_zero = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = '0;
  logic mem_req, mem_we, iord, ir_write, pc_write, pc_source, reg_write, mem_to_reg, instr_done, illegal_instr, mem_fault;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;
  logic [16:0] outs;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  multicycle_controller #(.MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal_instr(illegal_instr), .mem_fault(mem_fault), .state(state)
  );
  assign outs = {mem_req, mem_we, iord, ir_write, pc_write, pc_source, alu_src_a, alu_src_b, alu_op,
                 reg_write, mem_to_reg, instr_done, illegal_instr, mem_fault};
  localparam logic [16:0] O_FW  = 17'b100000_00_01_00_00000;
  localparam logic [16:0] O_FR  = 17'b100110_00_01_00_00000;
  localparam logic [16:0] O_DEC = 17'b000000_10_11_00_00000;
  localparam logic [16:0] O_MA  = 17'b000000_01_10_00_00000;
  localparam logic [16:0] O_MR  = 17'b101000_00_00_00_00000;
  localparam logic [16:0] O_MWW = 17'b111000_00_00_00_00000;
  localparam logic [16:0] O_MW  = 17'b111000_00_00_00_00100;
  localparam logic [16:0] O_MWB = 17'b000000_00_00_00_11100;
  localparam logic [16:0] O_ER  = 17'b000000_01_00_10_00000;
  localparam logic [16:0] O_EI  = 17'b000000_01_10_10_00000;
  localparam logic [16:0] O_AWB = 17'b000000_00_00_00_10100;
  localparam logic [16:0] O_BZ  = 17'b000011_01_00_01_00100;
  localparam logic [16:0] O_BN  = 17'b000001_01_00_01_00100;
  localparam logic [16:0] O_HI  = 17'b000000_00_00_00_00010;
  localparam logic [16:0] O_HF  = 17'b000000_00_00_00_00001;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, BEQ = 7'b1100011, OPI = 7'b0010011, OPR = 7'b0110011, BAD = 7'b1111111;
  typedef struct {
    logic r;
    logic [6:0] op;
    logic az;
    logic rdy;
    state_t st;
    logic [16:0] o;
  } vec_t;
  typedef struct {
    int row;
    state_t st;
    logic [16:0] o;
  } exp_t;
  vec_t vecs[$];
  exp_t exp_q[$];
  task automatic add(input logic r, input logic [6:0] op, input logic az, input logic rdy,
                     input state_t st, input logic [16:0] o, input int n = 1);
    repeat (n) vecs.push_back('{r, op, az, rdy, st, o});
  endtask
  task automatic check();
    exp_t e;
    if (exp_q.size() == 0) begin
      bad++;
      total++;
      $display("FAIL queue empty at t=%0t", $time);
      return;
    end
    e = exp_q.pop_front();
    total++;
    if (state !== 4'(e.st)) begin
      bad++;
      $display("FAIL row%0d state got %0d want %0d", e.row, state, e.st);
    end
    total++;
    if (outs !== e.o) begin
      bad++;
      $display("FAIL row%0d outs got %b want %b", e.row, outs, e.o);
    end
  endtask
  initial begin
    add(0, OPR, 0, 0, FETCH, O_FW);
    add(0, OPR, 0, 1, FETCH, O_FR); add(0, OPR, 0, 1, DECODE, O_DEC);
    add(0, OPR, 0, 1, EXEC_R, O_ER); add(0, OPR, 0, 1, ALU_WB, O_AWB);
    add(0, OPI, 0, 1, FETCH, O_FR); add(0, OPI, 0, 1, DECODE, O_DEC);
    add(0, OPI, 0, 1, EXEC_I, O_EI); add(0, OPI, 0, 1, ALU_WB, O_AWB);
    add(0, LD, 0, 0, FETCH, O_FW, 2); add(0, LD, 0, 1, FETCH, O_FR); add(0, LD, 0, 1, DECODE, O_DEC);
    add(0, LD, 0, 1, MEM_ADDR, O_MA); add(0, LD, 0, 0, MEM_READ, O_MR, 2); add(0, LD, 0, 1, MEM_READ, O_MR);
    add(0, LD, 0, 1, MEM_WB, O_MWB);
    add(0, ST, 0, 1, FETCH, O_FR); add(0, ST, 0, 1, DECODE, O_DEC); add(0, ST, 0, 1, MEM_ADDR, O_MA);
    add(0, ST, 0, 0, MEM_WRITE, O_MWW); add(0, ST, 0, 1, MEM_WRITE, O_MW);
    add(0, BEQ, 1, 1, FETCH, O_FR); add(0, BEQ, 1, 1, DECODE, O_DEC); add(0, BEQ, 1, 1, BRANCH, O_BZ);
    add(0, BEQ, 0, 1, FETCH, O_FR); add(0, BEQ, 0, 1, DECODE, O_DEC); add(0, BEQ, 0, 1, BRANCH, O_BN);
    add(0, ST, 0, 1, FETCH, O_FR); add(0, ST, 0, 1, DECODE, O_DEC); add(0, ST, 0, 1, MEM_ADDR, O_MA);
    add(1, ST, 0, 0, MEM_WRITE, O_MWW); add(0, ST, 0, 0, FETCH, O_FW);
    add(0, BAD, 0, 1, FETCH, O_FR); add(0, BAD, 0, 1, DECODE, O_DEC);
    add(0, BAD, 1, 1, HALT, O_HI, 21); add(1, BAD, 0, 0, HALT, O_HI);
    add(0, OPR, 0, 0, FETCH, O_FW, 8); add(0, OPR, 0, 0, HALT, O_HF, 4); add(1, OPR, 0, 0, HALT, O_HF);
    add(0, OPR, 0, 0, FETCH, O_FW, 7); add(0, OPR, 0, 1, FETCH, O_FR); add(0, OPR, 0, 1, DECODE, O_DEC);
    add(0, OPR, 0, 1, EXEC_R, O_ER); add(0, OPR, 0, 1, ALU_WB, O_AWB); add(0, OPR, 0, 0, FETCH, O_FW);
    repeat (2) @(posedge clk);
    @(negedge clk);
    foreach (vecs[i]) begin
      reset = vecs[i].r;
      opcode = vecs[i].op;
      alu_zero = vecs[i].az;
      mem_ready = vecs[i].rdy;
      exp_q.push_back('{i, vecs[i].st, vecs[i].o});
      #1;
      check();
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV64I-subset core (ld, sd, beq, addi-class, R-type ALU).
- Sequences the shared datapath (PC, IR, register file, ALU, immediate generator, data memory) one micro-step per cycle.
- Drives the select and enable lines, and waits on a unified instruction/data memory through a req/ready handshake.
- Sits beside the datapath. Takes opcode and ALU zero as inputs. Raises fault flags for illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles mem_req may stay high without mem_ready before a fault (range 1..65535).
- CNT_W, 16: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  instruction[6:0] from the IR; valid from DECODE onward
- alu_zero  in  1  ALU zero flag from the current cycle's ALU result
- mem_ready  in  1  memory has completed the access this cycle
- mem_req  out  1  memory access request; held until mem_ready
- mem_we  out  1  write strobe; qualified by mem_req
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR and old_pc from memory/PC
- pc_write  out  1  load PC from the pc_source mux
- pc_source  out  1  PC mux select: 0 = ALU result, 1 = ALUOut
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = reg A, 10 = old_pc
- alu_src_b  out  2  ALU B select: 00 = reg B, 01 = const 4, 10 = imm, 11 = imm<<1
- alu_op  out  2  ALU op class: 00 = add, 01 = sub, 10 = funct-decoded
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_instr  out  1  sticky flag: unsupported opcode decoded
- mem_fault  out  1  sticky flag: memory timeout
- state  out  4  current state encoding, for debug

Behaviour:
- Moore outputs, except where noted; all outputs are registered state decodes.
- Reset: state = FETCH, wait counter = 0, illegal_instr = 0, mem_fault = 0.
- Every output not listed for a state is 0 in that state.
- FETCH: mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1 (Mealy). The next state is then DECODE; otherwise stay.
- DECODE: alu_src_a=10, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 0000011/0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; anything else -> HALT with illegal_instr set.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00.
  - Next state: MEM_READ if opcode=0000011, else MEM_WRITE.
- MEM_READ: mem_req=1, iord=1. On mem_ready go to MEM_WB.
- MEM_WRITE: mem_req=1, mem_we=1, iord=1. On mem_ready: instr_done=1 (Mealy), go to FETCH.
- MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1. Next state FETCH.
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10. Next state ALU_WB.
- EXEC_I: alu_src_a=01, alu_src_b=10, alu_op=10. Next state ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_source=1, instr_done=1.
  - pc_write = alu_zero (Mealy). Next state FETCH.
- HALT: all strobes 0. Stays in HALT until reset; illegal_instr/mem_fault hold.
- Wait counter: clears on entry to any mem_req state and increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT without mem_ready: next state HALT, mem_fault=1.
  - mem_ready in the same cycle the count reaches MEM_TIMEOUT: completion wins, no fault.
- Latency with zero-wait memory (mem_ready already high): branch 3 cycles; R, I, store 4; load 5.
  - Each memory wait cycle adds exactly 1.
- Reset mid-instruction: the next cycle is FETCH with all strobes 0. No partial reg_write or mem_we may follow reset.
- mem_req never deasserts before mem_ready; mem_we and iord are stable while mem_req=1.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - State enum (FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WRITE, MEM_WB, EXEC_R, EXEC_I, ALU_WB, BRANCH, HALT).
  - Opcode constants (LOAD=0000011, STORE=0100011, BRANCH=1100011, OPIMM=0010011, OP=0110011).
  - alu_src_a/alu_src_b/alu_op encodings.
- One sub-module: mem_wait_timer, containing the counter, clear/enable logic and the timeout compare.

Test Plan:
- R-type add (opcode 0110011), mem_ready tied 1:
  - FETCH, DECODE, EXEC_R, ALU_WB, FETCH over 4 cycles.
  - reg_write=1 only in cycle 4; instr_done pulses once.
- Load with mem_ready low 2 cycles in both FETCH and MEM_READ: 9 cycles total; reg_write+mem_to_reg=1 in the final cycle; mem_req continuous during each wait.
- beq, run twice:
  - alu_zero=1 in BRANCH -> pc_write=1, pc_source=1.
  - alu_zero=0 -> pc_write=0.
  - Both cases return to FETCH the next cycle.
- Opcode 1111111 at DECODE -> HALT. illegal_instr=1 and stays 1 for 20 further cycles; all strobes 0; reset returns to FETCH with the flag cleared.
- mem_ready held 0 with MEM_TIMEOUT=8 -> mem_fault=1 and HALT after 8 request cycles. A repeat run with mem_ready=1 on wait cycle 8 completes with no fault.
- Reset asserted in the MEM_WRITE cycle -> next cycle state=FETCH, mem_we=0, reg_write=0, instr_done=0.
